// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS control unit (master) and its datapath (slave).
interface multicycle_control_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                pcwrite;
   logic                pcwritecond;
   logic                iord;
   logic                memread;
   logic                memwrite;
   logic                memtoreg;
   logic                irwrite;
   logic                alusrca;
   logic                regwrite;
   logic                regdst;
   logic [1:0]          pcsource;
   logic [1:0]          alusrcb;
   logic [ALUOP_W-1:0]  aluop;
   logic [3:0]          state;
   logic                instr_done;
   logic                mem_err;
   logic                illegal_op;

   modport master (
      input  opcode, mem_ready,
      output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
             alusrca, regwrite, regdst, pcsource, alusrcb, aluop, state,
             instr_done, mem_err, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
             alusrca, regwrite, regdst, pcsource, alusrcb, aluop, state,
             instr_done, mem_err, illegal_op
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM with memory-ready wait, timeout and done pulse.
// Define ILLEGAL_OP_TRAP_EN to route undefined opcodes to the TRAP state.
module multicycle_control #(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
      MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  REXEC  = 4'd7,
      RWB    = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, ADDIEX = 4'd11,
      ADDIWB = 4'd12, TRAP   = 4'd13
   } state_t;

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit TO_EN = (MEM_TIMEOUT > 0);

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

   state_t             state_r;
   state_t             next_state_s;
   logic [CNT_W-1:0]   wait_cnt_r;
   logic               mem_err_r;
   logic               wait_state_s;
   logic               timeout_s;

   assign wait_state_s = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
   assign timeout_s    = TO_EN && wait_state_s && !bus.mem_ready &&
                         (wait_cnt_r == CNT_W'(MEM_TIMEOUT));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Memory wait counter and sticky timeout flag; the counter saturates when the timeout is off
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_r <= {CNT_W{1'b0}};
         mem_err_r  <= 1'b0;
      end else begin
         if (wait_state_s && !bus.mem_ready && !timeout_s) begin
            if (wait_cnt_r != {CNT_W{1'b1}}) begin
               wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
               wait_cnt_r <= wait_cnt_r;
            end
         end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
         end
         if (timeout_s) begin
            mem_err_r <= 1'b1;
         end else begin
            mem_err_r <= mem_err_r;
         end
      end
   end

   // Next-state and Moore control decode
   always_comb begin
      next_state_s     = state_r;
      bus.pcwrite      = 1'b0;
      bus.pcwritecond  = 1'b0;
      bus.iord         = 1'b0;
      bus.memread      = 1'b0;
      bus.memwrite     = 1'b0;
      bus.memtoreg     = 1'b0;
      bus.irwrite      = 1'b0;
      bus.alusrca      = 1'b0;
      bus.regwrite     = 1'b0;
      bus.regdst       = 1'b0;
      bus.pcsource     = 2'b00;
      bus.alusrcb      = 2'b00;
      bus.aluop        = ALUOP_W'(2'b00);
      bus.instr_done   = 1'b0;
      bus.illegal_op   = 1'b0;
      case (state_r)
         IDLE: next_state_s = FETCH;
         FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = 2'b01;
            bus.irwrite = bus.mem_ready;
            bus.pcwrite = bus.mem_ready;
            if (bus.mem_ready) begin
               next_state_s = DECODE;
            end else if (timeout_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = FETCH;
            end
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            if (bus.opcode == OP_RTYPE) begin
               next_state_s = REXEC;
            end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
               next_state_s = MEMADR;
            end else if (bus.opcode == OP_BEQ) begin
               next_state_s = BRANCH;
            end else if (bus.opcode == OP_J) begin
               next_state_s = JUMP;
            end else if (bus.opcode == OP_ADDI) begin
               next_state_s = ADDIEX;
            end else begin
`ifdef ILLEGAL_OP_TRAP_EN
               next_state_s = TRAP;
`else
               next_state_s = FETCH;
`endif
            end
         end
         MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            if (bus.opcode == OP_SW) begin
               next_state_s = MEMWR;
            end else begin
               next_state_s = MEMRD;
            end
         end
         MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
            if (bus.mem_ready) begin
               next_state_s = MEMWB;
            end else if (timeout_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = MEMRD;
            end
         end
         MEMWB: begin
            bus.regwrite   = 1'b1;
            bus.memtoreg   = 1'b1;
            bus.instr_done = 1'b1;
            next_state_s   = FETCH;
         end
         MEMWR: begin
            bus.memwrite   = 1'b1;
            bus.iord       = 1'b1;
            bus.instr_done = bus.mem_ready;
            if (bus.mem_ready) begin
               next_state_s = FETCH;
            end else if (timeout_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = MEMWR;
            end
         end
         REXEC: begin
            bus.alusrca  = 1'b1;
            bus.aluop    = ALUOP_W'(2'b10);
            next_state_s = RWB;
         end
         RWB: begin
            bus.regwrite   = 1'b1;
            bus.regdst     = 1'b1;
            bus.instr_done = 1'b1;
            next_state_s   = FETCH;
         end
         BRANCH: begin
            bus.alusrca     = 1'b1;
            bus.aluop       = ALUOP_W'(2'b01);
            bus.pcwritecond = 1'b1;
            bus.pcsource    = 2'b01;
            bus.instr_done  = 1'b1;
            next_state_s    = FETCH;
         end
         JUMP: begin
            bus.pcwrite    = 1'b1;
            bus.pcsource   = 2'b10;
            bus.instr_done = 1'b1;
            next_state_s   = FETCH;
         end
         ADDIEX: begin
            bus.alusrca  = 1'b1;
            bus.alusrcb  = 2'b10;
            next_state_s = ADDIWB;
         end
         ADDIWB: begin
            bus.regwrite   = 1'b1;
            bus.instr_done = 1'b1;
            next_state_s   = FETCH;
         end
         TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
            bus.pcwrite    = 1'b1;
            bus.pcsource   = 2'b11;
            bus.illegal_op = 1'b1;
            bus.instr_done = 1'b1;
`endif
            next_state_s   = FETCH;
         end
         default: next_state_s = IDLE;
      endcase
   end

   assign bus.state   = state_r;
   assign bus.mem_err = mem_err_r;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory waits, timeout and reset.
module tb_multicycle_control;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) bus ();

   multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,alusrca,regwrite,regdst}
   function automatic logic [17:0] c(input logic [9:0] b, input logic [1:0] pcs,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic done, input logic ill);
      return {b, pcs, asb, aop, done, ill};
   endfunction

   function automatic logic [17:0] obs_ctrl();
      return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
              bus.memtoreg, bus.irwrite, bus.alusrca, bus.regwrite, bus.regdst,
              bus.pcsource, bus.alusrcb, bus.aluop, bus.instr_done, bus.illegal_op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: drive mem_ready, check state/controls, advance one clock.
   task automatic step(input string tag, input logic rdy, input logic [3:0] st,
                       input logic [17:0] ctl);
      bus.mem_ready = rdy;
      #1;
      chk({tag, ".state"}, 32'(bus.state), 32'(st));
      chk({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(ctl));
      @(negedge clk);
   endtask

   localparam logic [17:0] C_ZERO    = 18'd0;
   localparam logic [17:0] C_FETCH   = {10'b1001001000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_FWAIT   = {10'b0001000000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_DECODE  = {10'b0000000000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_MEMADR  = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_MEMRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_MEMWB   = {10'b0000010010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] C_MEMWRW  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_MEMWRD  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] C_REXEC   = {10'b0000000100, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
   localparam logic [17:0] C_RWB     = {10'b0000000011, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] C_BRANCH  = {10'b0100000100, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
   localparam logic [17:0] C_JUMP    = {10'b1000000000, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] C_ADDIEX  = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] C_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] C_TRAP    = {10'b1000000000, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1};

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode    = 6'b100011;
      repeat (2) @(negedge clk);
      chk("reset.mem_err", 32'(bus.mem_err), 32'd0);
      reset = 1'b0;
      step("idle", 1'b1, 4'd0, C_ZERO);

      // lw, no waits: 0,1,2,3,4,5,1
      step("lw.fetch", 1'b1, 4'd1, C_FETCH);
      step("lw.decode", 1'b1, 4'd2, C_DECODE);
      step("lw.memadr", 1'b1, 4'd3, C_MEMADR);
      step("lw.memrd", 1'b1, 4'd4, C_MEMRD);
      step("lw.memwb", 1'b1, 4'd5, C_MEMWB);

      // R-type; mem_ready low outside memory states must be ignored
      bus.opcode = 6'b000000;
      step("r.fetch", 1'b1, 4'd1, C_FETCH);
      step("r.decode", 1'b0, 4'd2, C_DECODE);
      step("r.rexec", 1'b0, 4'd7, C_REXEC);
      step("r.rwb", 1'b0, 4'd8, C_RWB);

      // sw with three wait cycles in MEMWR
      bus.opcode = 6'b101011;
      step("sw.fetch", 1'b1, 4'd1, C_FETCH);
      step("sw.decode", 1'b1, 4'd2, C_DECODE);
      step("sw.memadr", 1'b1, 4'd3, C_MEMADR);
      for (int i = 0; i < 3; i++) step("sw.memwr_wait", 1'b0, 4'd6, C_MEMWRW);
      step("sw.memwr_done", 1'b1, 4'd6, C_MEMWRD);

      bus.opcode = 6'b000100;
      step("beq.fetch", 1'b1, 4'd1, C_FETCH);
      step("beq.decode", 1'b1, 4'd2, C_DECODE);
      step("beq.branch", 1'b1, 4'd9, C_BRANCH);

      bus.opcode = 6'b000010;
      step("j.fetch", 1'b1, 4'd1, C_FETCH);
      step("j.decode", 1'b1, 4'd2, C_DECODE);
      step("j.jump", 1'b1, 4'd10, C_JUMP);

      bus.opcode = 6'b001000;
      step("addi.fetch", 1'b1, 4'd1, C_FETCH);
      step("addi.decode", 1'b1, 4'd2, C_DECODE);
      step("addi.ex", 1'b1, 4'd11, C_ADDIEX);
      step("addi.wb", 1'b1, 4'd12, C_ADDIWB);

      bus.opcode = 6'b111111;
      step("ill.fetch", 1'b1, 4'd1, C_FETCH);
      step("ill.decode", 1'b1, 4'd2, C_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
      step("ill.trap", 1'b1, 4'd13, C_TRAP);
`endif

      // 15 waits then ready on the cycle the counter hits the limit: ready wins
      bus.opcode = 6'b000010;
      for (int i = 0; i < 15; i++) step("fw.wait", 1'b0, 4'd1, C_FWAIT);
      step("fw.ready_at_limit", 1'b1, 4'd1, C_FETCH);
      step("fw.decode", 1'b1, 4'd2, C_DECODE);
      step("fw.jump", 1'b1, 4'd10, C_JUMP);
      chk("fw.no_err", 32'(bus.mem_err), 32'd0);

      // Timeout: 16 cycles in FETCH (counter 0..15), then IDLE with sticky mem_err
      for (int i = 0; i < 16; i++) step("to.wait", 1'b0, 4'd1, C_FWAIT);
      step("to.idle", 1'b0, 4'd0, C_ZERO);
      chk("to.mem_err", 32'(bus.mem_err), 32'd1);
      step("to.refetch", 1'b0, 4'd1, C_FWAIT);
      chk("to.mem_err_sticky", 32'(bus.mem_err), 32'd1);
      reset = 1'b1;
      #1;
      chk("to.reset_clears", 32'(bus.mem_err), 32'd0);
      chk("to.reset_state", 32'(bus.state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step("rst.idle", 1'b1, 4'd0, C_ZERO);

      // Reset asserted while a store is in progress
      bus.opcode = 6'b101011;
      step("abort.fetch", 1'b1, 4'd1, C_FETCH);
      step("abort.decode", 1'b1, 4'd2, C_DECODE);
      step("abort.memadr", 1'b1, 4'd3, C_MEMADR);
      step("abort.memwr", 1'b0, 4'd6, C_MEMWRW);
      #2;
      reset = 1'b1;
      #1;
      chk("abort.state", 32'(bus.state), 32'd0);
      chk("abort.ctrl", 32'(obs_ctrl()), 32'(C_ZERO));
      chk("abort.mem_err", 32'(bus.mem_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS control unit.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks, using one shared ALU and one shared memory port.
- Replaces the single-cycle opcode decoder in the datapath top level.
- Adds memory-ready handshaking, a memory timeout, an instruction-complete pulse and an optional illegal-opcode trap.

Parameters:
- OPCODE_W, 6, opcode width; compared against the 6-bit MIPS encodings, which are zero-extended.
- ALUOP_W, 2, width of aluop; must be at least 2; upper bits are driven 0.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  OPCODE_W  IR[31:26]; held stable by the IR outside FETCH.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst  out  1 each  datapath controls.
- pcsource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- alusrcb  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
- aluop  out  ALUOP_W  00 add, 01 subtract, 10 funct-decode.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- mem_err  out  1  sticky timeout flag.
- illegal_op  out  1  trap pulse.

Behaviour:
- Reset (asynchronous): state=IDLE(0), wait counter=0, mem_err=0. All outputs are 0 in IDLE.
- IDLE always advances to FETCH on the next clock.
- State encodings: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 REXEC7 RWB8 BRANCH9 JUMP10 ADDIEX11 ADDIWB12 TRAP13.
- Outputs are a pure function of state and mem_ready, registered nowhere. Any control not listed for a state is 0.
- FETCH: memread=1, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - 000000 -> REXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other opcode -> TRAP (with the trap feature) or FETCH (without it).
- MEMADR: alusrca=1, alusrcb=10. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: memread=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Next state FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready. On mem_ready: instr_done=1, next state FETCH.
- REXEC: alusrca=1, alusrcb=00, aluop=10. Next state RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Next state FETCH.
- BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01, instr_done=1. Next state FETCH.
- JUMP: pcwrite=1, pcsource=10, instr_done=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
- ADDIWB: regwrite=1, regdst=0, instr_done=1. Next state FETCH.
- Cycle counts, excluding memory wait cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Extra cycles = number of cycles with mem_ready low in FETCH, MEMRD and MEMWR.
- Wait counter:
  - Increments on each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready or when leaving those states.
- Timeout: if MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT while mem_ready=0, then next state is IDLE, mem_err is set to 1 and stays 1 until reset, and no instr_done is issued.
- mem_ready and timeout in the same cycle: mem_ready wins.
- Reset asserted mid-instruction: immediately IDLE with all controls 0. Any write pulse in progress is aborted.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - An undefined opcode goes DECODE -> TRAP.
  - TRAP drives pcwrite=1, pcsource=11, illegal_op=1 and instr_done=1 for one cycle, then goes to FETCH.
- Undefined:
  - TRAP is unreachable.
  - An undefined opcode goes DECODE -> FETCH with no writes, acting as a NOP. illegal_op is tied 0 and instr_done is 0 for that opcode.

Test Plan:
- Reset, then opcode=100011 with mem_ready=1 -> states 0,1,2,3,4,5,1. memread=1 in FETCH and MEMRD. MEMWB has regwrite=1, memtoreg=1, instr_done=1.
- opcode=000000 with mem_ready=1 -> 1,2,7,8,1. REXEC has aluop=10. RWB has regdst=1, regwrite=1.
- opcode=101011, mem_ready low for 3 cycles in MEMWR, then high -> memwrite=1 for 4 cycles. instr_done only on the 4th. Then FETCH.
- opcode=000100, then opcode=000010 -> BRANCH has pcwritecond=1, pcsource=01, aluop=01. JUMP has pcwrite=1, pcsource=10. Each instruction takes 3 cycles.
- mem_ready held 0 in FETCH with MEMTIMEOUT=15 -> after 15 wait cycles state=0, mem_err=1 and stays high. Reset clears it.
- opcode=111111 -> with ILLEGAL_OP_TRAP_EN: state 13, illegal_op=1, pcsource=11 for one cycle. Without it: 1,2,1 with no write strobes.
